// File: rtl/sdf_delay_mem.sv
// SDF FFT stage delay line: run-time programmable delay of D valid beats on a BANKS x LANES tile
// of 32x256 1rw1r macros. Define SDF_DELAY_PRIMED_ZERO_EN to force out_data to 0 until primed.
module sdf_delay_mem #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_DELAY = 256,
  parameter int unsigned DELAY_W   = $clog2(MAX_DELAY + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [DELAY_W-1:0] cfg_delay,
  output logic               cfg_err,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_primed
);
  localparam int unsigned Lanes = (DATA_W + 31) / 32;
  localparam int unsigned MemW  = Lanes * 32;
  localparam int unsigned Banks = MAX_DELAY / 256;
  localparam int unsigned AddrW = $clog2(MAX_DELAY);
  localparam int unsigned BankW = (Banks > 1) ? $clog2(Banks) : 1;
  localparam logic [DELAY_W-1:0] MaxDelay = DELAY_W'(MAX_DELAY);

  logic [DELAY_W-1:0] delay_q, delay_d, cnt_q, cnt_d, load_delay;
  logic [AddrW-1:0]   ptr_q, ptr_d, wp_addr_q, wp_addr_d;
  logic [MemW-1:0]    wp_data_q, wp_data_d, rd_sel;
  logic [BankW-1:0]   rd_bank_q, rd_bank_d, rd_bank, wr_bank;
  logic [DATA_W-1:0]  hold_q, hold_d, small_q, small_d;
  logic               primed_q, primed_d, err_q, err_d;
  logic               out_valid_q, out_valid_d, wp_valid_q, wp_valid_d;
  logic               mem_mode, unused_rd_hi;
  logic [Banks-1:0]   rd_cs, wr_cs;
  logic [7:0]         rd_word, wr_word;
  wire  [MemW-1:0]    bank_rdata [Banks];

  assign load_delay = (cfg_delay > MaxDelay) ? MaxDelay : cfg_delay;
  assign mem_mode   = (delay_q >= DELAY_W'(2));
  assign rd_bank    = BankW'(ptr_q >> 8);
  assign wr_bank    = BankW'(wp_addr_q >> 8);

  always_comb begin
    delay_d     = delay_q;
    err_d       = err_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    out_valid_d = 1'b0;
    wp_valid_d  = 1'b0;
    wp_addr_d   = wp_addr_q;
    wp_data_d   = wp_data_q;
    rd_bank_d   = rd_bank_q;
    hold_d      = hold_q;
    small_d     = small_q;
    rd_cs       = '0;
    wr_cs       = '0;
    rd_word     = ptr_q[7:0];
    wr_word     = wp_addr_q[7:0];
    // The pending write always lands one cycle after its beat, whatever happens on the inputs.
    if (wp_valid_q) wr_cs[wr_bank] = 1'b1;
    if (cfg_load) begin
      delay_d  = load_delay;
      err_d    = (cfg_delay > MaxDelay);
      ptr_d    = '0;
      cnt_d    = '0;
      primed_d = (load_delay == '0);
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      if (cnt_q == delay_q) primed_d = 1'b1;
      else                  cnt_d    = cnt_q + 1'b1;
      if (mem_mode) begin
        rd_cs[rd_bank] = 1'b1;
        rd_bank_d      = rd_bank;
        wp_valid_d     = 1'b1;
        wp_addr_d      = ptr_q;
        wp_data_d      = MemW'(in_data);
        ptr_d          = (DELAY_W'(ptr_q) == delay_q - 1'b1) ? '0 : ptr_q + 1'b1;
      end else begin
        small_d = (delay_q == '0) ? in_data : hold_q;
        hold_d  = in_data;
      end
    end
    if (reset) begin
      rd_cs = '0;
      wr_cs = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      delay_q     <= '0;
      err_q       <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      wp_valid_q  <= 1'b0;
      wp_addr_q   <= '0;
      wp_data_q   <= '0;
      rd_bank_q   <= '0;
      hold_q      <= '0;
      small_q     <= '0;
    end else begin
      delay_q     <= delay_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      wp_valid_q  <= wp_valid_d;
      wp_addr_q   <= wp_addr_d;
      wp_data_q   <= wp_data_d;
      rd_bank_q   <= rd_bank_d;
      hold_q      <= hold_d;
      small_q     <= small_d;
    end
  end

  // Behavioural stand-in for the 32x256 macro tile; all lanes of a bank share its chip selects.
  for (genvar b = 0; b < Banks; b++) begin : g_bank
    for (genvar l = 0; l < Lanes; l++) begin : g_lane
      logic [31:0] mem [256];
      logic [31:0] rdata_q;
      always_ff @(posedge clock) begin
        if (wr_cs[b]) mem[wr_word] <= wp_data_q[l*32 +: 32];
        if (rd_cs[b]) rdata_q <= mem[rd_word];
      end
      assign bank_rdata[b][l*32 +: 32] = rdata_q;
    end
  end

  assign rd_sel       = bank_rdata[rd_bank_q];
  assign unused_rd_hi = ^(rd_sel >> DATA_W);

  always_comb begin
    out_data = mem_mode ? rd_sel[DATA_W-1:0] : small_q;
`ifdef SDF_DELAY_PRIMED_ZERO_EN
    if (!primed_q) out_data = '0;
`endif
  end

  assign cfg_err    = err_q;
  assign out_valid  = out_valid_q;
  assign out_primed = primed_q;
endmodule

// File: tb/tb_sdf_delay_mem.sv
// Self-checking bench for sdf_delay_mem (MAX_DELAY=512, DATA_W=48) against a beat-level model.
module tb_sdf_delay_mem;
  localparam int unsigned DataW = 48;
  localparam int unsigned MaxD  = 512;
  localparam int unsigned DlyW  = 10;

  logic             clock = 1'b0;
  logic             reset = 1'b0, cfg_load = 1'b0, in_valid = 1'b0;
  logic [DlyW-1:0]  cfg_delay = '0;
  logic [DataW-1:0] in_data = '0;
  logic             cfg_err, out_valid, out_primed;
  logic [DataW-1:0] out_data;

  int checks = 0, failures = 0, cs1_seen = 0, cs0_seen = 0;

  // Model: the samples accepted since the last load, indexed by beat number.
  logic [DataW-1:0] hist[$];
  int               m_d, m_beats;
  logic             exp_valid, exp_primed, exp_err, exp_known;
  logic [DataW-1:0] exp_data;

  sdf_delay_mem #(.DATA_W(DataW), .MAX_DELAY(MaxD), .DELAY_W(DlyW)) dut (
    .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_delay(cfg_delay), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .out_primed(out_primed)
  );

  always #5 clock = ~clock;

  // Macro port hygiene: no shared address in one cycle, bank 1 selected only for addresses >= 256.
  always @(negedge clock) begin
    if (dut.rd_cs != '0) begin
      checks++;
      if (dut.rd_cs == dut.wr_cs && dut.rd_word == dut.wr_word) begin
        failures++;
        $display("FAIL rw_same_addr got word=%0d on both ports required distinct", dut.rd_word);
      end
      if (dut.rd_cs[0]) cs0_seen++;
    end
    if (dut.rd_cs[1]) begin
      checks++;
      cs1_seen++;
      if (dut.ptr_q < 9'd256) begin
        failures++;
        $display("FAIL bank1_rd_cs got addr=%0d required >=256", dut.ptr_q);
      end
    end
    if (dut.wr_cs[1]) begin
      checks++;
      if (dut.wp_addr_q < 9'd256) begin
        failures++;
        $display("FAIL bank1_wr_cs got addr=%0d required >=256", dut.wp_addr_q);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; cfg_load = 1'b0; in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    m_d = 0; m_beats = 0; hist.delete();
    exp_valid = 0; exp_primed = 0; exp_err = 0; exp_data = '0; exp_known = 1;
  endtask

  task automatic drive(input logic ld, input int dly, input logic v, input logic [DataW-1:0] d);
    cfg_load = ld; cfg_delay = DlyW'(dly); in_valid = v; in_data = d;
    @(posedge clock); #1;
    if (ld) begin
      m_d = (dly > int'(MaxD)) ? int'(MaxD) : dly;
      exp_err = (dly > int'(MaxD));
      hist.delete(); m_beats = 0;
      exp_valid = 0; exp_primed = (m_d == 0); exp_known = 0;
    end else begin
      exp_valid = v;
      if (v) begin
        hist.push_back(d);
        if (m_beats >= m_d) begin
          exp_data = hist[m_beats - m_d]; exp_known = 1; exp_primed = 1;
        end else exp_known = 0;
        m_beats++;
      end
    end
`ifdef SDF_DELAY_PRIMED_ZERO_EN
    if (!exp_primed) begin exp_data = '0; exp_known = 1; end
`endif
    cfg_load = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_data = 48'h123;
    do_reset();
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    if (out_primed !== 1'b0) begin failures++; $display("FAIL reset_primed got=%b exp=0", out_primed); end
    if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_basic_delay();
    do_reset();
    drive(1'b1, 4, 1'b0, '0);
    for (int i = 1; i <= 13; i++) begin
      drive(1'b0, 0, i <= 12, DataW'(i));
      checks += 3;
      if (out_valid !== exp_valid) begin failures++; $display("FAIL basic_valid i=%0d got=%b exp=%b", i, out_valid, exp_valid); end
      if (out_primed !== exp_primed) begin failures++; $display("FAIL basic_primed i=%0d got=%b exp=%b", i, out_primed, exp_primed); end
      if (exp_known && out_data !== exp_data) begin failures++; $display("FAIL basic_data i=%0d got=%h exp=%h", i, out_data, exp_data); end
      if (i == 5) begin
        checks++;
        if (out_data !== 48'd1 || out_primed !== 1'b1) begin
          failures++; $display("FAIL basic_fifth got=%h/%b exp=1/1", out_data, out_primed);
        end
      end
    end
  endtask

  task automatic test_gapped();
    logic [6:0]  pat = 7'b1011001;  // LSB first: 1,0,0,1,1,0,1
    logic [DataW-1:0] vals [4] = '{48'hA, 48'hB, 48'hC, 48'hD};
    int bi = 0;
    do_reset();
    drive(1'b1, 3, 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      logic v = (i < 7) ? pat[i] : 1'b0;
      drive(1'b0, 0, v, v ? vals[bi] : 48'hEEE);
      if (v) bi++;
      checks += 3;
      if (out_valid !== exp_valid) begin failures++; $display("FAIL gap_valid i=%0d got=%b exp=%b", i, out_valid, exp_valid); end
      if (out_primed !== exp_primed) begin failures++; $display("FAIL gap_primed i=%0d got=%b exp=%b", i, out_primed, exp_primed); end
      if (exp_known && out_data !== exp_data) begin failures++; $display("FAIL gap_data i=%0d got=%h exp=%h", i, out_data, exp_data); end
    end
    checks++;
    if (out_data !== 48'hA) begin failures++; $display("FAIL gap_fourth got=%h exp=a", out_data); end
  endtask

  task automatic test_small_delays();
    for (int dd = 0; dd < 2; dd++) begin
      drive(1'b1, dd, 1'b0, '0);
      for (int i = 0; i < 5; i++) begin
        drive(1'b0, 0, i < 2 + dd, DataW'(7 + i));
        checks += 3;
        if (out_valid !== exp_valid) begin failures++; $display("FAIL small_valid d=%0d i=%0d got=%b exp=%b", dd, i, out_valid, exp_valid); end
        if (out_primed !== exp_primed) begin failures++; $display("FAIL small_primed d=%0d i=%0d got=%b exp=%b", dd, i, out_primed, exp_primed); end
        if (exp_known && out_data !== exp_data) begin failures++; $display("FAIL small_data d=%0d i=%0d got=%h exp=%h", dd, i, out_data, exp_data); end
      end
    end
  endtask

  task automatic test_clamp_reload();
    drive(1'b1, 600, 1'b0, '0);
    checks++;
    if (cfg_err !== 1'b1) begin failures++; $display("FAIL clamp_err got=%b exp=1", cfg_err); end
    for (int i = 0; i < 520; i++) begin
      drive(1'b0, 0, 1'b1, DataW'(1000 + i));
      checks += 3;
      if (out_primed !== exp_primed) begin failures++; $display("FAIL clamp_primed i=%0d got=%b exp=%b", i, out_primed, exp_primed); end
      if (cfg_err !== exp_err) begin failures++; $display("FAIL clamp_err_hold i=%0d got=%b exp=%b", i, cfg_err, exp_err); end
      if (exp_known && out_data !== exp_data) begin failures++; $display("FAIL clamp_data i=%0d got=%h exp=%h", i, out_data, exp_data); end
    end
    drive(1'b1, 2, 1'b1, 48'hBAD);
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reload_drop got=%b exp=0", out_valid); end
    if (cfg_err !== 1'b0) begin failures++; $display("FAIL reload_err got=%b exp=0", cfg_err); end
    if (out_primed !== 1'b0) begin failures++; $display("FAIL reload_primed got=%b exp=0", out_primed); end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 0, 1'b1, DataW'(50 + i));
      checks += 3;
      if (out_valid !== exp_valid) begin failures++; $display("FAIL reload_valid i=%0d got=%b exp=%b", i, out_valid, exp_valid); end
      if (out_primed !== exp_primed) begin failures++; $display("FAIL reload_primed2 i=%0d got=%b exp=%b", i, out_primed, exp_primed); end
      if (exp_known && out_data !== exp_data) begin failures++; $display("FAIL reload_data i=%0d got=%h exp=%h", i, out_data, exp_data); end
    end
  endtask

  task automatic test_bank_crossing();
    int k = 0;
    drive(1'b1, 300, 1'b0, '0);
    while (k < 900) begin
      logic v = ($urandom_range(0, 5) != 0);
      drive(1'b0, 0, v, v ? DataW'(k) | (DataW'(k) << 32) : '0);
      if (v) k++;
      checks += 2;
      if (out_valid !== exp_valid) begin failures++; $display("FAIL bank_valid k=%0d got=%b exp=%b", k, out_valid, exp_valid); end
      if (exp_known && out_data !== exp_data) begin failures++; $display("FAIL bank_data k=%0d got=%h exp=%h", k, out_data, exp_data); end
    end
    checks++;
    if (cs1_seen == 0 || cs0_seen == 0) begin
      failures++; $display("FAIL bank_coverage got cs0=%0d cs1=%0d required both >0", cs0_seen, cs1_seen);
    end
  endtask

  task automatic test_random_reload();
    int dlys [10] = '{0, 1, 2, 3, 17, 255, 256, 257, 512, 700};
    for (int r = 0; r < 8; r++) begin
      int dly = dlys[$urandom_range(0, 9)];
      drive(1'b1, dly, $urandom_range(0, 1), '0);
      for (int i = 0; i < 600; i++) begin
        logic v = ($urandom_range(0, 3) != 0);
        drive(1'b0, 0, v, {$urandom, $urandom});
        checks += 4;
        if (out_valid !== exp_valid) begin failures++; $display("FAIL rand_valid d=%0d i=%0d got=%b exp=%b", dly, i, out_valid, exp_valid); end
        if (out_primed !== exp_primed) begin failures++; $display("FAIL rand_primed d=%0d i=%0d got=%b exp=%b", dly, i, out_primed, exp_primed); end
        if (cfg_err !== exp_err) begin failures++; $display("FAIL rand_err d=%0d got=%b exp=%b", dly, cfg_err, exp_err); end
        if (exp_known && out_data !== exp_data) begin failures++; $display("FAIL rand_data d=%0d i=%0d got=%h exp=%h", dly, i, out_data, exp_data); end
      end
    end
  endtask

  task automatic test_primed_zero();
    logic [DataW-1:0] stale;
`ifdef SDF_DELAY_PRIMED_ZERO_EN
    stale = '0;
`else
    stale = 48'hFFFF_FFFF;
`endif
    do_reset();
    drive(1'b1, 8, 1'b0, '0);
    for (int i = 0; i < 16; i++) drive(1'b0, 0, 1'b1, 48'hFFFF_FFFF);
    drive(1'b0, 0, 1'b0, '0);
    drive(1'b0, 0, 1'b0, '0);
    do_reset();
    drive(1'b1, 8, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 0, 1'b1, DataW'(i + 1));
      checks++;
      if (i < 8) begin
        if (out_data !== stale) begin failures++; $display("FAIL prime_stale i=%0d got=%h exp=%h", i, out_data, stale); end
      end else if (out_data !== exp_data) begin
        failures++; $display("FAIL prime_data i=%0d got=%h exp=%h", i, out_data, exp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_delay();
    test_gapped();
    test_small_delays();
    test_clamp_reload();
    test_bank_crossing();
    test_random_reload();
    test_primed_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdf_delay_mem.md
Name: sdf_delay_mem

Overview:
- Parametrised SDF FFT stage delay line: a run-time-programmable delay buffer of D valid beats.
- Storage is a BANKS x LANES tile of 32x256 1rw1r SRAM macros, with a register path for D < 2.
- Replaces the fixed 32x256 per-stage memory, so one instance serves any stage of a variable-size FFT.
- Sits between the SDF butterfly output and the feedback input.

Parameters:
- DATA_W, 32, sample width in bits; LANES = ceil(DATA_W/32) macros side by side, unused upper bits tied to 0.
- MAX_DELAY, 256, largest supported delay; must be a multiple of 256; BANKS = MAX_DELAY/256.
- DELAY_W, clog2(MAX_DELAY+1), width of the delay configuration field.

Ports:
- clock  in  1  single clock for the logic and all macros (both macro ports)
- reset  in  1  synchronous, active-high
- cfg_load  in  1  one-cycle pulse; latches cfg_delay
- cfg_delay  in  DELAY_W  requested delay D in beats, 0..MAX_DELAY
- cfg_err  out  1  sticky; set when the loaded delay exceeds MAX_DELAY; cleared by reset or by a legal load
- in_valid  in  1  sample beat qualifier
- in_data  in  DATA_W  input sample
- out_valid  out  1  in_valid delayed by exactly one cycle
- out_data  out  DATA_W  sample from D beats earlier
- out_primed  out  1  high once D beats have been accepted since the last load/reset

Behaviour:
- Reset:
  - D=0, ptr=0, beat counter=0.
  - out_valid=0, out_data=0, out_primed=0, cfg_err=0.
  - Write-pending register cleared.
  - No macro is enabled during the reset cycle.
- cfg_load:
  - D is latched from cfg_delay; values above MAX_DELAY are clamped to MAX_DELAY and set cfg_err.
  - ptr, beat counter, write-pending register and out_primed are cleared in the same cycle.
  - An in_valid coinciding with cfg_load is discarded: no write, and no out_valid next cycle.
  - Memory contents are not cleared.
- Latency: out_valid(t+1) = in_valid(t) for every non-load, non-reset cycle t, independent of D.
- Memory path (D >= 2):
  - On an accepted beat: issue a read at ptr (port R) and capture {ptr, in_data} into the write-pending register.
  - The write-pending register is written via port W on the following cycle, unconditionally.
  - ptr advances ptr = (ptr == D-1) ? 0 : ptr+1.
  - The read at ptr returns, one cycle later, the sample written D beats earlier. out_data takes the macro read data directly, with no extra register.
  - Read and write never target the same address in one cycle, because D >= 2 guarantees this. The macro read-during-write hazard is therefore never exercised.
- Bank decode:
  - bank = ptr[msb:8], word = ptr[7:0].
  - Only the selected bank's chip select is asserted on each port; all lanes of that bank are enabled together.
  - Read data is muxed by the bank index registered alongside the read.
- D = 1: a single register holds the last accepted sample; out_data = that register's value before the current update. Macros are idle.
- D = 0: out_data = in_data registered one cycle (pure pipeline); out_primed = 1 immediately after the load.
- out_primed:
  - The beat counter increments per accepted beat and saturates at D.
  - out_primed is set on the cycle the counter reaches D, so the first out_valid carrying real data has out_primed=1.
- Idle behaviour: with in_valid=0, ptr holds, out_valid=0 and out_data holds its previous value.
- Reset mid-stream: a pending write is dropped, and that data is lost; this is accepted.

Optional Feature:
- Macro name: SDF_DELAY_PRIMED_ZERO_EN.
- When defined: out_data is forced to 0 whenever out_primed=0. The first FFT frame after a load/reset therefore sees zeros, not stale SRAM contents.
- When undefined: out_data is the raw memory/register value while unprimed (contents undefined after power-up); this variant needs no extra mux.

Test Plan:
- Basic delay: reset; load D=4; stream 1,2,3,...,12 continuously -> out_valid lags in_valid by 1 cycle; out_data from the 5th beat onward = 1,2,3,...; out_primed rises with that 5th output.
- Bank crossing: MAX_DELAY=512, DATA_W=48; load D=300; stream a 0..899 ramp -> beat k outputs k-300; both banks and both lanes are exercised; the bank-1 chip select is active only when ptr >= 256; no same-address R/W in any cycle (assertion).
- Gapped input: D=3; in_valid pattern 1,0,0,1,1,0,1 carrying A,B,C,D -> outputs follow beats, not cycles (the 4th beat outputs A); ptr holds during gaps.
- Small delays: D=0 with input 7,8 -> outputs 7,8 one cycle later; D=1 with input 7,8,9 -> outputs are x(or 0 with feature),7,8.
- Clamp and reload: load D=600 with MAX_DELAY=512 -> cfg_err=1 and effective delay 512. Mid-stream load D=2 with in_valid=1 -> that beat is dropped, out_primed=0 until 2 new beats arrive, and cfg_err clears.
- Optional feature: with SDF_DELAY_PRIMED_ZERO_EN, preload the memory with 0xFFFFFFFF, reset, D=8 -> the first 8 outputs are 0. Without the macro, the first 8 outputs are 0xFFFFFFFF.
